// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives requests; the slave (adder) returns status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped over the operands LSB first.
// The result is published on entry to DONE and held until the next DONE.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 on the final bit so it never wraps mid-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_c   <= bus.cin;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_co;
                    r_res <= {w_s, r_res[WIDTH-1:1]};
                    if (w_last) begin
                        r_sum  <= {w_s, r_res[WIDTH-1:1]};
                        r_cout <= w_co;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.busy  = (r_state == RUN);
    assign bus.done  = (r_state == DONE);
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8.
// Expected results are queued at stimulus time, observed ones at done.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         n_done   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         done_t[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.done === 1'b1) begin
            got_q.push_back({bus.cout, bus.sum});
            done_t.push_back(cyc);
            n_done++;
        end
    end

    function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, logic c);
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    task automatic drive(logic [7:0] a, logic [7:0] b, logic c);
        bus.a   = a;
        bus.b   = b;
        bus.cin = c;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        drive(8'hA5, 8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        checks++;
        if ({bus.cout, bus.sum} !== 9'h000) begin
            failures++;
            $display("FAIL reset_result got=%h exp=000", {bus.cout, bus.sum});
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [8:0] g, e;
        drive(8'h00, 8'h00, 1'b0);
        bus.start = 1'b1;
        exp_q.push_back(model(8'h00, 8'h00, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        drive(8'hFF, 8'hFF, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy cyc%0d busy=%b done=%b exp busy=1 done=0",
                         k, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency done=%b busy=%b exp done=1 busy=0",
                     bus.done, bus.busy);
        end
        checks++;
        if (got_q.size() == 0) begin
            failures++; $display("FAIL basic_result got=none exp=%h", exp_q[0]);
            void'(exp_q.pop_front());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (g !== e) begin
                failures++; $display("FAIL basic_result got=%h exp=%h", g, e);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_pulse done=%b ready=%b exp done=0 ready=1",
                     bus.done, bus.ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] ta[4] = '{8'h01, 8'hA5, 8'hFF, 8'h3C};
        logic [7:0] tb_[4] = '{8'hFF, 8'h5A, 8'hFF, 8'h0F};
        logic       tc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [8:0] g, e;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 20 && bus.ready !== 1'b1; k++) @(negedge clk);
            drive(ta[i], tb_[i], tc[i]);
            bus.start = 1'b1;
            exp_q.push_back(model(ta[i], tb_[i], tc[i]));
            @(negedge clk);
            bus.start = 1'b0;
            drive(~ta[i], ~tb_[i], ~tc[i]);
            for (int k = 0; k < 20 && got_q.size() == 0; k++) @(negedge clk);
            checks++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                failures++; $display("FAIL vec%0d got=timeout exp=%h", i, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++; $display("FAIL vec%0d got=%h exp=%h", i, g, e);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int         n0;
        logic [8:0] g, e;
        @(negedge clk);
        n0 = n_done;
        drive(8'h01, 8'h01, 1'b0);
        bus.start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h01, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        drive(8'h10, 8'h20, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drive(8'hFF, 8'hFF, 1'b1);
        for (int k = 0; k < 20 && got_q.size() == 0; k++) @(negedge clk);
        checks++;
        e = exp_q.pop_front();
        if (got_q.size() == 0) begin
            failures++; $display("FAIL ignore_result got=timeout exp=%h", e);
        end else begin
            g = got_q.pop_front();
            if (g !== e) begin
                failures++; $display("FAIL ignore_result got=%h exp=%h", g, e);
            end
        end
        repeat (15) @(negedge clk);
        checks++;
        if (n_done - n0 != 1 || got_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_count dones=%0d exp=1", n_done - n0);
            got_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int         n0;
        logic [8:0] g, e;
        drive(8'h55, 8'h22, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n0 = n_done;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state ready=%b busy=%b done=%b exp 1/0/0",
                     bus.ready, bus.busy, bus.done);
        end
        checks++;
        if ({bus.cout, bus.sum} !== 9'h000) begin
            failures++;
            $display("FAIL midreset_result got=%h exp=000", {bus.cout, bus.sum});
        end
        repeat (12) @(negedge clk);
        checks++;
        if (n_done != n0) begin
            failures++;
            $display("FAIL midreset_nodone dones=%0d exp=0", n_done - n0);
            got_q.delete();
        end
        drive(8'h77, 8'h19, 1'b0);
        bus.start = 1'b1;
        exp_q.push_back(model(8'h77, 8'h19, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20 && got_q.size() == 0; k++) @(negedge clk);
        checks++;
        e = exp_q.pop_front();
        if (got_q.size() == 0) begin
            failures++; $display("FAIL midreset_after got=timeout exp=%h", e);
        end else begin
            g = got_q.pop_front();
            if (g !== e) begin
                failures++; $display("FAIL midreset_after got=%h exp=%h", g, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int         n0;
        int         rc;
        logic [8:0] g, e;
        n0 = done_t.size();
        rc = 0;
        drive(8'h12, 8'h34, 1'b0);
        bus.start = 1'b1;
        repeat (3) exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        for (int k = 0; k < 60 && got_q.size() < 3; k++) begin
            @(negedge clk);
            if ((done_t.size() - n0) inside {1, 2} && bus.ready === 1'b1) rc++;
        end
        bus.start = 1'b0;
        checks++;
        if (got_q.size() < 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size());
        end else begin
            checks++;
            if (done_t[n0+1] - done_t[n0] != 10 || done_t[n0+2] - done_t[n0+1] != 10) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=10,10",
                         done_t[n0+1] - done_t[n0], done_t[n0+2] - done_t[n0+1]);
            end
            checks++;
            if (rc != 2) begin
                failures++; $display("FAIL b2b_ready got=%0d exp=2", rc);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                failures++; $display("FAIL b2b_result%0d got=none exp=%h", i, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++; $display("FAIL b2b_result%0d got=%h exp=%h", i, g, e);
                end
            end
        end
        repeat (12) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            failures++; $display("FAIL b2b_extra got=%0d exp=0", got_q.size());
        end
    endtask

    initial begin
        bus.start = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only while ready=1.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; captured on the accepted start.
REQ-008 SHALL have port ready  output  1  high when IDLE and able to accept start.
REQ-009 SHALL have port busy  output  1  high while bits are being processed (RUN).
REQ-010 SHALL have port done  output  1  one-cycle pulse; sum/cout valid.
REQ-011 SHALL have port sum  output  WIDTH  result bits a+b+cin, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 SHALL sequence one internal 1-bit full adder (s = x^y^c, c' = xy|xc|yc) over the operands, one bit per cycle, LSB first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; ready = (state==IDLE), busy = (state==RUN), done = (state==DONE).
REQ-015 IDLE: on edge with start=1, SHALL latch a, b into shift registers, latch cin into carry flop, clear bit counter to 0, go to RUN; start=0 stays IDLE.
REQ-016 RUN: each edge SHALL add the current LSBs with the carry flop, shift the sum bit into the result register from the MSB side, shift operands right by one, update carry flop, increment counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 (counter==WIDTH-1), SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: start accepted at edge T -> done high in the cycle after edge T+WIDTH (WIDTH+1 edges after acceptance).
REQ-020 sum and cout SHALL be updated only at entry to DONE and SHALL hold their values through IDLE until the next DONE.
REQ-021 start asserted while busy=1 or done=1 SHALL be ignored (no restart, no queueing); it is accepted only if still high once ready=1.
REQ-022 Changes on a, b, cin after acceptance SHALL not affect the result in progress.
REQ-023 Back-to-back: start held high continuously SHALL produce one addition every WIDTH+2 cycles.
REQ-024 Counter SHALL be ceil(log2(WIDTH)) bits minimum and SHALL not wrap within one operation.

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, sum=0, cout=0, carry flop=0, counter=0, operand registers=0, regardless of state.
REQ-026 Resulting outputs after reset: ready=1, busy=0, done=0.
REQ-027 reset SHALL take priority over start in the same cycle; an operation interrupted by reset SHALL be abandoned with no done pulse.

Verification (WIDTH=8)
REQ-028 Reset, then start with a=0x00, b=0x00, cin=0 -> busy high 8 cycles, done pulse on 9th cycle after acceptance, sum=0x00, cout=0.
REQ-029 a=0x01, b=0xFF, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-030 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
REQ-031 Pulse start with a=0x10, b=0x20 during RUN of a prior 0x01+0x01 op -> only 0x02 result, no second done; operands changed mid-RUN leave result unchanged.
REQ-032 Assert reset in 4th RUN cycle -> next cycle ready=1, busy=0, sum=0, cout=0, no done pulse; new start afterwards completes correctly.
REQ-033 Hold start=1 for three ops -> done pulses exactly 10 cycles apart, ready low between accepts.
